// File: rtl/imem_program_loader_pkg.sv
// ----------------------------------------------------------------------------
// imem_program_loader_pkg
//   Shared definitions for the instruction-memory program loader:
//   loader FSM state encoding, default memory geometry and the logic
//   levels used to drive the core reset.
// ----------------------------------------------------------------------------
package imem_program_loader_pkg;

    localparam int IMEM_ADDR_WIDTH = 10;
    localparam int INSTR_WIDTH     = 32;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    typedef enum logic [2:0] {
        L_IDLE,
        L_LOAD,
        L_WFLUSH,
        L_VERIFY,
        L_DONE,
        L_ERROR
    } loader_state_e;

endpackage : imem_program_loader_pkg

// File: rtl/imem_checksum.sv
// ----------------------------------------------------------------------------
// imem_checksum
//   Modular (wrap-around) accumulator. The sum wraps modulo 2**WIDTH.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-low reset, clears the sum
//   clr   in   synchronous clear, takes priority over en
//   en    in   add din into the sum this cycle
//   din   in   value to accumulate
//   sum   out  registered running sum
// ----------------------------------------------------------------------------
module imem_checksum
    import imem_program_loader_pkg::*;
#(
    parameter int WIDTH = INSTR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (en) begin
            sum_d = sum_q + din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule : imem_checksum

// File: rtl/imem_program_loader.sv
// ----------------------------------------------------------------------------
// imem_program_loader
//   Loads a program into the instruction memory from a valid/ready word
//   stream, reads every written word back, and compares a checksum of the
//   written words against a checksum of the read-back words. The CPU core
//   is held in reset until the program verifies.
//
// Ports:
//   clk           in   system clock, all logic on posedge
//   rst           in   synchronous active-low reset
//   start         in   single-cycle load request
//   num_words     in   program length, sampled when start is taken
//   s_valid       in   stream word valid
//   s_data        in   stream instruction word
//   s_ready       out  loader accepts a word this cycle
//   im_we         out  instruction-memory write enable
//   im_re         out  instruction-memory read enable
//   im_addr       out  word address shared by write and read
//   im_wdata      out  write data
//   im_rdata      in   read data, valid one cycle after im_re
//   cpu_rst       out  active-high core reset
//   busy          out  load or verify in progress
//   done          out  program loaded and verified
//   error         out  bad length or checksum mismatch
//   words_loaded  out  words accepted in the current load
// ----------------------------------------------------------------------------
module imem_program_loader #(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int MAX_WORDS   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH:0]    num_words,
    input  logic                   s_valid,
    input  logic [INSTR_WIDTH-1:0] s_data,
    output logic                   s_ready,
    output logic                   im_we,
    output logic                   im_re,
    output logic [ADDR_WIDTH-1:0]  im_addr,
    output logic [INSTR_WIDTH-1:0] im_wdata,
    input  logic [INSTR_WIDTH-1:0] im_rdata,
    output logic                   cpu_rst,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_WIDTH:0]    words_loaded
);

    import imem_program_loader_pkg::*;

    localparam int CW = ADDR_WIDTH + 1;

    loader_state_e          state_q,    state_d;
    logic [CW-1:0]          n_q,        n_d;
    // The accepted-word count doubles as the write index: both advance on
    // every transfer and start at zero.
    logic [CW-1:0]          cnt_q,      cnt_d;
    logic [CW-1:0]          rd_idx_q,   rd_idx_d;
    logic                   s_ready_q,  s_ready_d;
    logic                   im_we_q,    im_we_d;
    logic                   im_re_q,    im_re_d;
    logic                   re_d1_q,    re_d1_d;
    logic [ADDR_WIDTH-1:0]  im_addr_q,  im_addr_d;
    logic [INSTR_WIDTH-1:0] im_wdata_q, im_wdata_d;
    logic                   cpu_rst_q,  cpu_rst_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;
    logic                   error_q,    error_d;

    logic                   len_ok;
    logic                   xfer;
    logic                   sum_clr;
    logic [INSTR_WIDTH-1:0] wsum;
    logic [INSTR_WIDTH-1:0] rsum;
    logic [INSTR_WIDTH-1:0] rsum_final;

    assign len_ok = (num_words != '0) && (num_words <= CW'(MAX_WORDS));
    // s_ready is only ever high in LOAD, so this is the LOAD handshake.
    assign xfer   = s_valid && s_ready_q;

    // The last read word arrives in the cycle the comparison is made, so it
    // is folded into the read sum here rather than waiting another cycle.
    assign rsum_final = rsum + im_rdata;

    // NOTE: every signal written in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        rd_idx_d   = rd_idx_q;
        s_ready_d  = s_ready_q;
        im_we_d    = 1'b0;
        im_re_d    = 1'b0;
        re_d1_d    = im_re_q;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        sum_clr    = 1'b0;

        unique case (state_q)
            L_IDLE, L_DONE, L_ERROR: begin
                if (start) begin
                    if (len_ok) begin
                        state_d   = L_LOAD;
                        n_d       = num_words;
                        cnt_d     = '0;
                        rd_idx_d  = '0;
                        s_ready_d = 1'b1;
                        sum_clr   = 1'b1;
                    end else begin
                        state_d   = L_ERROR;
                    end
                end
            end

            L_LOAD: begin
                if (xfer) begin
                    im_we_d    = 1'b1;
                    im_addr_d  = cnt_q[ADDR_WIDTH-1:0];
                    im_wdata_d = s_data;
                    cnt_d      = cnt_q + CW'(1);
                    if (cnt_q + CW'(1) == n_q) begin
                        s_ready_d = 1'b0;
                        state_d   = L_WFLUSH;
                    end
                end
            end

            // The final write is on the bus during this cycle; the first
            // read is scheduled for the next one so they never overlap.
            L_WFLUSH: begin
                state_d   = L_VERIFY;
                rd_idx_d  = '0;
                im_re_d   = 1'b1;
                im_addr_d = '0;
            end

            L_VERIFY: begin
                if (im_re_q) begin
                    if (rd_idx_q != n_q - CW'(1)) begin
                        im_re_d   = 1'b1;
                        rd_idx_d  = rd_idx_q + CW'(1);
                        im_addr_d = rd_idx_d[ADDR_WIDTH-1:0];
                    end
                end else begin
                    state_d = (rsum_final == wsum) ? L_DONE : L_ERROR;
                end
            end

            default: begin
                state_d = L_IDLE;
            end
        endcase

        busy_d  = (state_d inside {L_LOAD, L_WFLUSH, L_VERIFY});
        done_d  = (state_d == L_DONE);
        error_d = (state_d == L_ERROR);
        // The core leaves reset one cycle after DONE is entered, and goes
        // back into reset on the same edge that leaves DONE.
        cpu_rst_d = (state_q == L_DONE && state_d == L_DONE) ? LOW : HIGH;
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= L_IDLE;
            n_q        <= '0;
            cnt_q      <= '0;
            rd_idx_q   <= '0;
            s_ready_q  <= 1'b0;
            im_we_q    <= 1'b0;
            im_re_q    <= 1'b0;
            re_d1_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            cpu_rst_q  <= HIGH;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            rd_idx_q   <= rd_idx_d;
            s_ready_q  <= s_ready_d;
            im_we_q    <= im_we_d;
            im_re_q    <= im_re_d;
            re_d1_q    <= re_d1_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    imem_checksum #(.WIDTH(INSTR_WIDTH)) u_wsum (
        .clk (clk),
        .rst (rst),
        .clr (sum_clr),
        .en  (xfer),
        .din (s_data),
        .sum (wsum)
    );

    // Read data is valid the cycle after each im_re, hence the delayed enable.
    imem_checksum #(.WIDTH(INSTR_WIDTH)) u_rsum (
        .clk (clk),
        .rst (rst),
        .clr (sum_clr),
        .en  (re_d1_q),
        .din (im_rdata),
        .sum (rsum)
    );

    assign s_ready      = s_ready_q;
    assign im_we        = im_we_q;
    assign im_re        = im_re_q;
    assign im_addr      = im_addr_q;
    assign im_wdata     = im_wdata_q;
    assign cpu_rst      = cpu_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = cnt_q;

endmodule : imem_program_loader

// File: tb/tb_imem_program_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_program_loader
//   Self-checking bench for imem_program_loader. A behavioural instruction
//   memory (with optional single-address read corruption) sits on the memory
//   port; expected checksums, write sequences and latencies are computed
//   from the program contents.
// ----------------------------------------------------------------------------
module tb_imem_program_loader;

    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int MAXW = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   num_words;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          im_we;
    logic          im_re;
    logic [AW-1:0] im_addr;
    logic [DW-1:0] im_wdata;
    logic [DW-1:0] im_rdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    imem_program_loader #(
        .INSTR_WIDTH (DW),
        .ADDR_WIDTH  (AW),
        .MAX_WORDS   (MAXW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_words    (num_words),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .im_we        (im_we),
        .im_re        (im_re),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .im_rdata     (im_rdata),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Behavioural instruction memory: synchronous write, 1-cycle read.
    logic [DW-1:0] mem [0:MAXW-1];
    logic          corrupt_en   = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;

    always @(posedge clk) begin
        if (im_we) mem[im_addr] <= im_wdata;
        if (im_re) im_rdata <= mem[im_addr] ^
                               ((corrupt_en && im_addr == corrupt_addr) ? 32'h1 : 32'h0);
    end

    // Write/overlap monitor, sampled mid-cycle.
    int            cyc_cnt = 0;
    logic [AW-1:0] wr_addr_log [$];
    logic [DW-1:0] wr_data_log [$];
    int            wr_cyc_log  [$];
    int            overlap_cnt = 0;

    always @(posedge clk) cyc_cnt++;

    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wr_addr_log.push_back(im_addr);
            wr_data_log.push_back(im_wdata);
            wr_cyc_log.push_back(cyc_cnt);
        end
        if (im_we === 1'b1 && im_re === 1'b1) overlap_cnt++;
    end

    logic [DW-1:0] prog [0:MAXW-1];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_log.delete();
        wr_data_log.delete();
        wr_cyc_log.delete();
        overlap_cnt = 0;
    endtask

    // Full load/verify run of prog[0..n-1]. vmode: 0 valid always high,
    // 1 valid every other cycle, 2 random valid.
    task automatic run_program(input int n, input int vmode, input bit corrupt,
                               input int caddr, input bit poke_start, input string name);
        logic [DW-1:0] wsum_m, rsum_m;
        bit            exp_ok, was_end, rdy, vld;
        int            idx, cyc, lat, first_bad, nbad;

        wsum_m = '0;
        rsum_m = '0;
        for (int i = 0; i < n; i++) begin
            wsum_m += prog[i];
            rsum_m += (corrupt && i == caddr) ? (prog[i] ^ 32'h1) : prog[i];
        end
        exp_ok       = (wsum_m == rsum_m);
        corrupt_en   = corrupt;
        corrupt_addr = caddr[AW-1:0];
        clear_log();
        was_end = (done === 1'b1) || (error === 1'b1);

        start     = 1'b1;
        num_words = n[AW:0];
        tick();
        start = 1'b0;

        if (was_end) begin
            checks++;
            if ({done, error, cpu_rst, busy} !== 4'b0011) begin
                errors++;
                $display("FAIL %s restart_flags: got {done,error,cpu_rst,busy}=%b expected 0011",
                         name, {done, error, cpu_rst, busy});
            end
        end

        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 20000) begin
            rdy = s_ready;
            case (vmode)
                0:       vld = 1'b1;
                1:       vld = (cyc % 2 == 0);
                default: vld = 1'($urandom_range(0, 1));
            endcase
            s_valid = vld;
            s_data  = prog[idx];
            if (poke_start && cyc == 3) begin
                start     = 1'b1;
                num_words = '0;
            end
            tick();
            start = 1'b0;
            if (rdy && vld) idx++;
            cyc++;
        end
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL %s load_timeout: accepted %0d words, required %0d", name, idx, n);
        end

        // Offer extra words; none may be taken.
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;

        checks++;
        if (s_ready !== 1'b0 || words_loaded !== n[AW:0]) begin
            errors++;
            $display("FAIL %s after_last: got s_ready=%b words_loaded=%0d expected 0 and %0d",
                     name, s_ready, words_loaded, n);
        end

        lat = 0;
        while (!(done === 1'b1 || error === 1'b1) && lat < n + 100) begin
            tick();
            lat++;
        end
        s_valid = 1'b0;

        checks++;
        if (lat != n + 2) begin
            errors++;
            $display("FAIL %s verify_latency: got %0d cycles expected %0d", name, lat, n + 2);
        end

        checks++;
        if ({done, error, cpu_rst, busy} !== {exp_ok, !exp_ok, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL %s result_flags: got {done,error,cpu_rst,busy}=%b expected %b",
                     name, {done, error, cpu_rst, busy}, {exp_ok, !exp_ok, 1'b1, 1'b0});
        end

        tick();
        checks++;
        if (cpu_rst !== !exp_ok) begin
            errors++;
            $display("FAIL %s cpu_rst_after: got %b expected %b", name, cpu_rst, !exp_ok);
        end

        checks++;
        if (wr_addr_log.size() != n) begin
            errors++;
            $display("FAIL %s write_count: got %0d writes expected %0d", name, wr_addr_log.size(), n);
        end

        nbad      = 0;
        first_bad = -1;
        for (int i = 0; i < n && i < wr_addr_log.size(); i++) begin
            if (wr_addr_log[i] !== 10'(i) || wr_data_log[i] !== prog[i] ||
                (vmode == 0 && wr_cyc_log[i] != wr_cyc_log[0] + i)) begin
                if (first_bad < 0) first_bad = i;
                nbad++;
            end
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL %s write_seq: %0d bad writes, first #%0d addr=%0d data=%h expected addr=%0d data=%h",
                     name, nbad, first_bad, wr_addr_log[first_bad], wr_data_log[first_bad],
                     first_bad, prog[first_bad]);
        end

        checks++;
        if (overlap_cnt != 0 || words_loaded !== n[AW:0]) begin
            errors++;
            $display("FAIL %s overlap_count: got overlap=%0d words_loaded=%0d expected 0 and %0d",
                     name, overlap_cnt, words_loaded, n);
        end
        corrupt_en = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        start     = 1'b0;
        num_words = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        repeat (2) tick();
        checks++;
        if ({s_ready, im_we, im_re, busy, done, error, cpu_rst} !== 7'b0000001 ||
            im_addr !== '0 || im_wdata !== '0 || words_loaded !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got flags=%b addr=%h wdata=%h wl=%0d expected 0000001/0/0/0",
                     {s_ready, im_we, im_re, busy, done, error, cpu_rst}, im_addr, im_wdata, words_loaded);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({s_ready, busy, done, error, cpu_rst} !== 5'b00001) begin
            errors++;
            $display("FAIL idle_outputs: got %b expected 00001", {s_ready, busy, done, error, cpu_rst});
        end
    endtask

    task automatic test_basic();
        prog[0] = 32'h0000_0001;
        prog[1] = 32'h0000_0002;
        prog[2] = 32'h0000_0003;
        run_program(3, 0, 1'b0, 0, 1'b0, "basic3");
    endtask

    task automatic test_bad_length();
        int nlog;
        clear_log();
        start     = 1'b1;
        num_words = '0;
        tick();
        start = 1'b0;
        checks++;
        if ({error, done, cpu_rst, busy, s_ready} !== 5'b10100) begin
            errors++;
            $display("FAIL len0: got {error,done,cpu_rst,busy,s_ready}=%b expected 10100",
                     {error, done, cpu_rst, busy, s_ready});
        end
        start     = 1'b1;
        num_words = 11'(MAXW + 1);
        tick();
        start = 1'b0;
        repeat (3) tick();
        nlog = wr_addr_log.size();
        checks++;
        if (error !== 1'b1 || cpu_rst !== 1'b1 || nlog != 0) begin
            errors++;
            $display("FAIL len_over: got error=%b cpu_rst=%b writes=%0d expected 1 1 0",
                     error, cpu_rst, nlog);
        end
        prog[0] = 32'h2008_0005;
        run_program(1, 0, 1'b0, 0, 1'b0, "single_after_err");
    endtask

    task automatic test_toggle_valid();
        for (int i = 0; i < 4; i++) prog[i] = $urandom;
        run_program(4, 1, 1'b0, 0, 1'b1, "toggle4");
    endtask

    task automatic test_corrupt();
        for (int i = 0; i < 6; i++) prog[i] = $urandom;
        run_program(6, 0, 1'b1, 1, 1'b0, "corrupt_a1");
    endtask

    task automatic test_reset_mid_load();
        int  acc, cyc, nlog;
        bit  rdy;
        start     = 1'b1;
        num_words = 11'd5;
        tick();
        start = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < 2 && cyc < 50) begin
            rdy     = s_ready;
            s_valid = 1'b1;
            s_data  = $urandom;
            tick();
            if (rdy) acc++;
            cyc++;
        end
        s_valid = 1'b0;
        rst     = 1'b0;
        tick();
        checks++;
        if ({s_ready, im_we, im_re, busy, done, error, cpu_rst} !== 7'b0000001 ||
            words_loaded !== '0) begin
            errors++;
            $display("FAIL mid_load_reset: got flags=%b wl=%0d expected 0000001 and 0",
                     {s_ready, im_we, im_re, busy, done, error, cpu_rst}, words_loaded);
        end
        nlog = wr_addr_log.size();
        rst  = 1'b1;
        s_valid = 1'b1;
        repeat (5) tick();
        s_valid = 1'b0;
        checks++;
        if (wr_addr_log.size() != nlog || s_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got extra_writes=%0d s_ready=%b busy=%b expected 0 0 0",
                     wr_addr_log.size() - nlog, s_ready, busy);
        end
    endtask

    task automatic test_single_word();
        prog[0] = $urandom;
        run_program(1, 0, 1'b0, 0, 1'b0, "single_n1");
    endtask

    task automatic test_random();
        int n, ca;
        bit cr;
        for (int t = 0; t < 4; t++) begin
            n  = $urandom_range(1, 64);
            cr = 1'($urandom_range(0, 1));
            ca = $urandom_range(0, n - 1);
            for (int i = 0; i < n; i++) prog[i] = $urandom;
            run_program(n, 2, cr, ca, 1'b0, "random");
        end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < MAXW; i++) prog[i] = 32'hFFFF_FFFF;
        run_program(MAXW, 0, 1'b0, 0, 1'b0, "full_1024");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_length();
        test_toggle_valid();
        test_corrupt();
        test_reset_mid_load();
        test_single_word();
        test_random();
        test_full_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_imem_program_loader
